// File: rtl/proc_clk_enable_gen.sv
// Multi-channel fractional clock-enable generator: each channel pulses at f_ref*num/den.
// Optional feature macro CLK_TOGGLE_EN adds per-channel divide-by-two debug outputs.
module proc_clk_enable_gen #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int RST_NUM     = 3,
  parameter int RST_DEN     = 20,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_num,
  input  logic [DIV_W-1:0]  cfg_den,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] outclk_en,
  output logic              locked
`ifdef CLK_TOGGLE_EN
  ,
  output logic [NUM_CH-1:0] outclk_tgl
`endif
);

  localparam int                LCK_W     = $clog2(LOCK_CYCLES + 1);
  localparam logic [CH_W:0]     NUM_CH_V  = (CH_W + 1)'(NUM_CH);
  localparam logic [LCK_W-1:0]  LOCK_MAX  = LCK_W'(LOCK_CYCLES);
  localparam logic [DIV_W-1:0]  RST_NUM_V = DIV_W'(RST_NUM);
  localparam logic [DIV_W-1:0]  RST_DEN_V = DIV_W'(RST_DEN);

  logic             wr_ok_s;
  logic [LCK_W-1:0] lock_cnt_r;
  logic [LCK_W-1:0] lock_nxt_s;
  logic             locked_r;
  logic             cfg_err_r;

  // Write legality: channel in range, non-zero denominator, ratio not above one.
  always_comb begin
    wr_ok_s = cfg_we && ({1'b0, cfg_ch} < NUM_CH_V) &&
              (cfg_den != {DIV_W{1'b0}}) && (cfg_num <= cfg_den);
  end

  // Lock counter next value: cleared by any accepted write, otherwise saturating count.
  always_comb begin
    if (wr_ok_s) begin
      lock_nxt_s = {LCK_W{1'b0}};
    end else if (lock_cnt_r == LOCK_MAX) begin
      lock_nxt_s = lock_cnt_r;
    end else begin
      lock_nxt_s = lock_cnt_r + LCK_W'(1'b1);
    end
  end

  // Shared status registers; locked looks at the next count so it rises on the LOCK_CYCLES-th edge.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_cnt_r <= {LCK_W{1'b0}};
      locked_r   <= 1'b0;
      cfg_err_r  <= 1'b0;
    end else begin
      lock_cnt_r <= lock_nxt_s;
      locked_r   <= (lock_nxt_s == LOCK_MAX);
      cfg_err_r  <= cfg_we && !wr_ok_s;
    end
  end

  assign locked  = locked_r;
  assign cfg_err = cfg_err_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [CH_W-1:0] CH_IDX = CH_W'(g);

    logic [DIV_W-1:0] acc_r;
    logic [DIV_W-1:0] num_r;
    logic [DIV_W-1:0] den_r;
    logic [DIV_W-1:0] acc_nxt_s;
    logic [DIV_W:0]   sum_s;
    logic [DIV_W:0]   diff_s;
    logic             wrap_s;
    logic             sel_s;
    logic             en_r;

    // Phase accumulator step; acc stays below den so one extra bit holds the sum.
    always_comb begin
      sum_s  = {1'b0, acc_r} + {1'b0, num_r};
      diff_s = sum_s - {1'b0, den_r};
      wrap_s = (sum_s >= {1'b0, den_r});
      sel_s  = wr_ok_s && (cfg_ch == CH_IDX);
      if (wrap_s) begin
        acc_nxt_s = diff_s[DIV_W-1:0];
      end else begin
        acc_nxt_s = sum_s[DIV_W-1:0];
      end
    end

    // Channel state: an accepted write restarts the phase and wins over a coincident wrap.
    always_ff @(posedge refclk) begin
      if (rst) begin
        acc_r <= {DIV_W{1'b0}};
        num_r <= RST_NUM_V;
        den_r <= RST_DEN_V;
        en_r  <= 1'b0;
      end else if (sel_s) begin
        acc_r <= {DIV_W{1'b0}};
        num_r <= cfg_num;
        den_r <= cfg_den;
        en_r  <= 1'b0;
      end else begin
        acc_r <= acc_nxt_s;
        en_r  <= wrap_s;
      end
    end

    assign outclk_en[g] = en_r;

`ifdef CLK_TOGGLE_EN
    logic tgl_r;

    // Debug square wave: flips at the end of each cycle in which the enable is high.
    always_ff @(posedge refclk) begin
      if (rst) begin
        tgl_r <= 1'b0;
      end else if (sel_s) begin
        tgl_r <= 1'b0;
      end else begin
        tgl_r <= tgl_r ^ en_r;
      end
    end

    assign outclk_tgl[g] = tgl_r;
`endif
  end

endmodule
